// File: rtl/mips_store_tap_if.sv
// Store-tap bus: the snooped write/PC signals from mips_top plus the capture stream and status.
// master drives the inputs side (bench/CPU); slave is the tap itself.
interface mips_store_tap_if #(
  parameter int MMIO_AW = 4,
  parameter int FIFO_AW = 3
);
  logic                 we_dm;
  logic [31:0]          alu_out;
  logic [31:0]          wd_dm;
  logic [31:0]          pc_current;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [MMIO_AW-3:0]   out_off;
  logic [FIFO_AW:0]     fifo_count;
  logic                 overflow;
  logic                 halted;
  logic [31:0]          run_cycles;

  modport master (
    output we_dm, alu_out, wd_dm, pc_current, out_ready,
    input  out_valid, out_data, out_off, fifo_count, overflow, halted, run_cycles
  );

  modport slave (
    input  we_dm, alu_out, wd_dm, pc_current, out_ready,
    output out_valid, out_data, out_off, fifo_count, overflow, halted, run_cycles
  );
endinterface

// File: rtl/mips_store_tap.sv
// MMIO store snooper with FIFO stream output and PC-based halt detector.
// Define STORE_TAP_CYCLE_CNT_EN to implement the run-cycle counter; otherwise run_cycles is 0.
module mips_store_tap #(
  parameter logic [31:0] MMIO_BASE = 32'h0000_0080,
  parameter int          MMIO_AW   = 4,
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] HALT_PC   = 32'h0000_0064
) (
  input  logic            clk,
  input  logic            rst,
  mips_store_tap_if.slave bus
);
  localparam int OFF_W = MMIO_AW - 2;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [31:0]      data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  entry_t         mem_q [DEPTH];
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic           ovf_q, ovf_d;
  logic           hit, full, empty, pop, push;
  state_e         state_q, state_d;

  assign hit = bus.we_dm
            && (bus.alu_out[31:MMIO_AW] == MMIO_BASE[31:MMIO_AW])
            && (bus.alu_out[1:0] == 2'b00);

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW])
              && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = hit && (!full || pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (hit && full && !pop) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[FIFO_AW-1:0]] <= '{off: bus.alu_out[MMIO_AW-1:2], data: bus.wd_dm};
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = mem_q[rd_q[FIFO_AW-1:0]].data;
  assign bus.out_off    = mem_q[rd_q[FIFO_AW-1:0]].off;
  assign bus.fifo_count = wr_q - rd_q;
  assign bus.overflow   = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.pc_current != 32'h0)   state_d = S_RUN;
      S_RUN:    if (bus.pc_current == HALT_PC) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.halted = (state_q == S_HALTED);
  end

`ifdef STORE_TAP_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_RUN && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign bus.run_cycles = cyc_q;
`else
  assign bus.run_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_mips_store_tap.sv
// Directed bench for mips_store_tap: vector table for FIFO behaviour, hand sequences for
// full push+pop, halt detection and asynchronous mid-stream reset.
module tb_mips_store_tap;
  localparam int MMIO_AW = 4;
  localparam int FIFO_AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_store_tap_if #(.MMIO_AW(MMIO_AW), .FIFO_AW(FIFO_AW)) bus ();

  mips_store_tap #(
    .MMIO_BASE (32'h0000_0080),
    .MMIO_AW   (MMIO_AW),
    .FIFO_AW   (FIFO_AW),
    .HALT_PC   (32'h0000_0064)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        exp_valid;
    logic [1:0]  exp_off;
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
    logic        exp_ovf;
    bit          chk_head;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef STORE_TAP_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic ready, input logic ev, input logic [1:0] eoff,
                         input logic [31:0] edata, input logic [3:0] ecnt, input logic eovf,
                         input bit chk);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.ready = ready;
    v.exp_valid = ev; v.exp_off = eoff; v.exp_data = edata;
    v.exp_count = ecnt; v.exp_ovf = eovf; v.chk_head = chk;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic ready);
    bus.we_dm = we; bus.alu_out = addr; bus.wd_dm = data; bus.out_ready = ready;
  endtask

  // One clock edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.pc_current = 32'h0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.pc_current = 32'h0;

    // Filtering: below window, above window, misaligned, write disabled.
    add_vec(1, 32'h7C, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 32'h90, 32'h22, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 32'h82, 32'h33, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 32'h80, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    // Single hit, then drain it.
    add_vec(1, 32'h84, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 1, 0, 1);
    add_vec(0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    // Empty with push and pop: pop ignored, push lands.
    add_vec(1, 32'h88, 32'h55, 1, 1, 2, 32'h55, 1, 0, 1);
    add_vec(0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    // Nine hits with no consumer: eight fit, the ninth is dropped.
    for (int i = 1; i <= 9; i++)
      add_vec(1, 32'h80 + 32'((i - 1) % 4) * 4, 32'(i), 0,
              1, 0, 32'd1, 4'((i > 8) ? 8 : i), (i == 9), 1);
    // Drain: heads 2..8 follow in order, overflow stays sticky.
    for (int j = 1; j <= 8; j++)
      add_vec(0, 32'h0, 32'h0, 1, (j < 8), 2'(j % 4), 32'(j + 1), 4'(8 - j), 1, (j < 8));

    do_reset();
    #1;
    check("reset_valid", 32'(bus.out_valid), 0);
    check("reset_count", 32'(bus.fifo_count), 0);
    check("reset_ovf", 32'(bus.overflow), 0);
    check("reset_halted", 32'(bus.halted), 0);
    check("reset_cycles", bus.run_cycles, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].we, vecs[k].addr, vecs[k].data, vecs[k].ready);
      step();
      check($sformatf("v%0d_valid", k), 32'(bus.out_valid), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_count", k), 32'(bus.fifo_count), 32'(vecs[k].exp_count));
      check($sformatf("v%0d_ovf", k), 32'(bus.overflow), 32'(vecs[k].exp_ovf));
      if (vecs[k].chk_head) begin
        check($sformatf("v%0d_data", k), bus.out_data, vecs[k].exp_data);
        check($sformatf("v%0d_off", k), 32'(bus.out_off), 32'(vecs[k].exp_off));
      end
    end

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h80 + 32'((i - 1) % 4) * 4, 32'h10 + 32'(i), 1'b0);
      step();
    end
    check("full_count", 32'(bus.fifo_count), 8);
    check("full_head", bus.out_data, 32'h11);
    drive(1'b1, 32'h8C, 32'h99, 1'b1);
    step();
    check("pp_count", 32'(bus.fifo_count), 8);
    check("pp_ovf", 32'(bus.overflow), 0);
    check("pp_head", bus.out_data, 32'h12);
    check("pp_off", 32'(bus.out_off), 1);
    for (int j = 1; j <= 7; j++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      step();
      check($sformatf("pp_drain%0d", j), bus.out_data, (j == 7) ? 32'h99 : 32'h12 + 32'(j));
      check($sformatf("pp_dcount%0d", j), 32'(bus.fifo_count), 32'(8 - j));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("pp_empty", 32'(bus.out_valid), 0);

    // Halt detection: two idle edges at PC 0, then 4, 8, ... 0x64.
    do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.pc_current = 32'h0;
    step();
    step();
    check("idle_halted", 32'(bus.halted), 0);
    check("idle_cycles", bus.run_cycles, 0);
    for (int pc = 4; pc <= 32'h64; pc += 4) begin
      bus.pc_current = 32'(pc);
      if (pc == 32'h64) check("pre_halt", 32'(bus.halted), 0);
      step();
      if (pc == 8) check("first_run_cnt", bus.run_cycles, CNT_EN ? 32'd1 : 32'd0);
    end
    check("halted", 32'(bus.halted), 1);
    check("run_cycles", bus.run_cycles, CNT_EN ? 32'd24 : 32'd0);
    for (int pc = 32'h68; pc <= 32'h70; pc += 4) begin
      bus.pc_current = 32'(pc);
      step();
    end
    check("halt_hold", 32'(bus.halted), 1);
    check("cycles_hold", bus.run_cycles, CNT_EN ? 32'd24 : 32'd0);

    // Capture after halt, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(i) * 4, 32'hA0 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("post_halt_count", 32'(bus.fifo_count), 3);
    check("post_halt_head", bus.out_data, 32'hA0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_count", 32'(bus.fifo_count), 0);
    check("arst_ovf", 32'(bus.overflow), 0);
    check("arst_halted", 32'(bus.halted), 0);
    check("arst_cycles", bus.run_cycles, 0);
    bus.pc_current = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("after_rst_valid", 32'(bus.out_valid), 0);
    check("after_rst_halted", 32'(bus.halted), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
